i2c_reg_bank_ctrl: RTL and testbench
====================================

// Module: i2c_reg_bank_ctrl
// PURPOSE
//  Register-bank controller behind i2c_simple_slave; consumes its strobes and drives its tx byte and stall.
//  Gives the host a pointer-addressed bank of 2**PTR_W byte registers: write = [ptr][data...], read = [data...] from ptr.
//  RW registers drive fabric (LEDs, RGB); RO registers return live fabric inputs (buttons, status).
// PARAMETERS
//  PTR_W    3      pointer width; NUM_REGS = 2**PTR_W
//  RO_MASK  8'h00  NUM_REGS bits; bit i=1 -> reg i read-only (reads reg_hw_in[i], writes dropped)
//  RST_VAL  8'h00  reset value of every RW register
// PORTS
//  clk                   in   1            system clock (ICE_CLK at top)
//  rst                   in   1            async reset, active-high
//  i2c_addr_rw           in   8            {addr[6:0], rw}; rw=1 read; slave already address-filtered
//  i2c_addr_rw_valid_stb in   1            1-cycle: address byte accepted (START or repeated START)
//  i2c_data_rx           in   8            received data byte
//  i2c_data_rx_valid_stb in   1            1-cycle: i2c_data_rx valid
//  i2c_data_tx           out  8            byte the slave transmits next (registered)
//  i2c_data_tx_loaded_stb in  1            1-cycle: slave latched i2c_data_tx into shifter
//  i2c_data_tx_done_stb  in   1            1-cycle: tx byte finished (ack/nack sampled)
//  i2c_error_stb         in   1            1-cycle: bus error / unexpected STOP
//  stall                 out  1            to slave: hold SCL low until tx byte is fresh
//  reg_q                 out  8*NUM_REGS   RW register contents, reg i at [8i+7:8i]
//  reg_wr_stb            out  NUM_REGS     1-cycle pulse when reg i written
//  reg_hw_in             in   8*NUM_REGS   fabric values returned for RO registers
//  ptr                   out  PTR_W        current pointer (debug)
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0, reg_q=RST_VAL for all, reg_wr_stb=0, i2c_data_tx=0, stall=0.
//  States: IDLE, PTR (awaiting pointer byte), WR (data writes), RD (data reads).
//  Any state, addr_valid_stb: rw=0 -> PTR; rw=1 -> RD with stall=1 (repeated START supported).
//  PTR, rx_stb: ptr <= i2c_data_rx[PTR_W-1:0] (upper bits ignored); -> WR.
//  WR, rx_stb: if !RO_MASK[ptr] reg[ptr] <= rx, reg_wr_stb[ptr]=1 next cycle; RO: no write, no strobe;
//    ptr advances in both cases (see CONFIGURATION).
//  RD, tx_loaded_stb: ptr advances; stall=1 until refresh completes.
//  i2c_data_tx <= RO_MASK[ptr] ? reg_hw_in[ptr] : reg_q[ptr]; updated every cycle, 1-cycle latency from ptr.
//  stall: set on RD entry or RD ptr advance; cleared 2 cycles later (ptr settle + tx refresh). Never high outside RD.
//  tx_done_stb: no state change (NACK end-of-read handled by slave; STOP/START returns via strobes).
//  error_stb -> IDLE, stall=0; ptr and registers retained. Error wins over rx/tx/addr strobe in same cycle.
//  Data byte in IDLE or RD (rx_stb): ignored. tx_loaded_stb outside RD: ignored.
//  Pointer arithmetic modulo NUM_REGS: ptr=NUM_REGS-1 advances to 0.
//  Pointer persists across transactions: write [ptr] only, then read, reads from that ptr.
//  Async rst mid-transfer: all to reset values immediately; stall released; slave recovers on next START.
// CONFIGURATION
//  I2C_REG_AUTOINC_EN defined: ptr += 1 after every WR data byte and every RD tx_loaded_stb (burst access).
//  Not defined: ptr changes only in PTR state; repeated bytes hit same register (FIFO-style/polling).
//    RD stall still asserted on entry only; no stall on tx_loaded_stb.
// TESTING
//  Reset, write 0x42/W [0x01, 0xA5] -> reg_q[1]=0xA5, reg_wr_stb=8'b0000_0010 for 1 cycle, others RST_VAL.
//  AUTOINC: write [0x06, 0x11, 0x22, 0x33] -> reg6=0x11, reg7=0x22, reg0=0x33 (wrap), ptr=1.
//  RO_MASK=8'h80, reg_hw_in[7]=0xFF: write [0x07, 0x55] -> no strobe, reg7 unchanged; read 1 byte -> 0xFF.
//  Write [0x02], repeated START read 3 bytes (AUTOINC) -> reg2, reg3, reg4 returned; stall pulses 2 cycles each.
//  error_stb same cycle as rx_stb in WR -> no write, state IDLE, ptr unchanged; next read uses old ptr.
//  Without I2C_REG_AUTOINC_EN: write [0x03, 0x10, 0x20] -> reg3=0x20, two strobes on bit 3, ptr=3.

Source files
------------

// File: rtl/i2c_reg_bank_ctrl.sv
// Pointer-addressed byte register bank served over an i2c_simple_slave strobe interface.
// Latency: register write and reg_wr_stb one cycle after rx strobe; i2c_data_tx one cycle after ptr.
// Backpressure: stall holds SCL for two cycles on read entry (and on each read pointer advance with autoinc).
//
// Optional feature macro: I2C_REG_AUTOINC_EN
//   defined     -> ptr increments after every write data byte and every read byte load (burst access)
//   not defined -> ptr only changes from the pointer byte; repeated bytes hit the same register
//
// Ports:
//   clk, rst                 system clock, asynchronous active-high reset
//   i2c_addr_rw(_valid_stb)  address byte {addr[6:0], rw} and its accept strobe
//   i2c_data_rx(_valid_stb)  received data byte and its strobe
//   i2c_data_tx              registered byte the slave transmits next
//   i2c_data_tx_loaded_stb   slave latched i2c_data_tx into its shifter
//   i2c_data_tx_done_stb     tx byte finished (no action needed here)
//   i2c_error_stb            bus error / unexpected STOP, aborts to IDLE
//   stall                    hold SCL low while the tx byte is being refreshed
//   reg_q, reg_wr_stb        RW register contents (reg i at [8i+7:8i]) and per-register write pulses
//   reg_hw_in                live fabric values returned for read-only registers
//   ptr                      current register pointer (debug)
module i2c_reg_bank_ctrl #(
    parameter int                        PTR_W   = 3,
    parameter logic [(2**PTR_W)-1:0]     RO_MASK = '0,
    parameter logic [7:0]                RST_VAL = 8'h00
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   i2c_addr_rw,
    input  logic                         i2c_addr_rw_valid_stb,
    input  logic [7:0]                   i2c_data_rx,
    input  logic                         i2c_data_rx_valid_stb,
    output logic [7:0]                   i2c_data_tx,
    input  logic                         i2c_data_tx_loaded_stb,
    input  logic                         i2c_data_tx_done_stb,
    input  logic                         i2c_error_stb,
    output logic                         stall,
    output logic [8*(2**PTR_W)-1:0]      reg_q,
    output logic [(2**PTR_W)-1:0]        reg_wr_stb,
    input  logic [8*(2**PTR_W)-1:0]      reg_hw_in,
    output logic [PTR_W-1:0]             ptr
);

    localparam int NUM_REGS = 2**PTR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PTR  = 2'd1,
        WR   = 2'd2,
        RD   = 2'd3
    } state_t;

    state_t                 state_q;
    state_t                 state_nxt;
    logic [PTR_W-1:0]       ptr_q;
    logic [PTR_W-1:0]       ptr_nxt;
    logic [7:0]             reg_mem [NUM_REGS];
    logic [7:0]             hw_arr  [NUM_REGS];
    logic                   wr_en;
    logic [NUM_REGS-1:0]    wr_stb_nxt;
    logic                   stall_set;
    logic                   stall_clr;
    // Counts the remaining stall cycles: one for the pointer to settle,
    // one for i2c_data_tx to be refreshed from it.
    logic [1:0]             stall_cnt;

    // tx_done needs no action and only the rw bit of the address byte
    // matters (the slave already filtered the address).
    logic                   unused_ok;
    assign unused_ok = ^{i2c_addr_rw[7:1], i2c_data_tx_done_stb, i2c_data_tx_loaded_stb};

    assign ptr   = ptr_q;
    assign stall = (stall_cnt != 2'd0);

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_q[8*i +: 8] = reg_mem[i];
            hw_arr[i]       = reg_hw_in[8*i +: 8];
        end
    end

    // Next-state logic. Priority: error, then address strobe (START or
    // repeated START from any state), then the per-state data strobes.
    always_comb begin
        state_nxt = state_q;
        ptr_nxt   = ptr_q;
        wr_en     = 1'b0;
        stall_set = 1'b0;
        stall_clr = 1'b0;

        if (i2c_error_stb) begin
            state_nxt = IDLE;
            stall_clr = 1'b1;
        end else if (i2c_addr_rw_valid_stb) begin
            if (i2c_addr_rw[0]) begin
                state_nxt = RD;
                stall_set = 1'b1;
            end else begin
                state_nxt = PTR;
                stall_clr = 1'b1;
            end
        end else begin
            case (state_q)
                PTR: begin
                    if (i2c_data_rx_valid_stb) begin
                        ptr_nxt   = i2c_data_rx[PTR_W-1:0];
                        state_nxt = WR;
                    end
                end
                WR: begin
                    if (i2c_data_rx_valid_stb) begin
                        // Writes to read-only registers are dropped silently.
                        wr_en = !RO_MASK[ptr_q];
`ifdef I2C_REG_AUTOINC_EN
                        ptr_nxt = ptr_q + PTR_W'(1);
`endif
                    end
                end
                RD: begin
`ifdef I2C_REG_AUTOINC_EN
                    // The slave has taken the current byte; move on and hold
                    // SCL until the next byte has been fetched.
                    if (i2c_data_tx_loaded_stb) begin
                        ptr_nxt   = ptr_q + PTR_W'(1);
                        stall_set = 1'b1;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        wr_stb_nxt = '0;
        if (wr_en) begin
            wr_stb_nxt[ptr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_nxt;
            ptr_q   <= ptr_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 2'd0;
        end else if (stall_set) begin
            stall_cnt <= 2'd2;
        end else if (stall_clr) begin
            stall_cnt <= 2'd0;
        end else if (stall_cnt != 2'd0) begin
            stall_cnt <= stall_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_mem[i] <= RST_VAL;
            end
            reg_wr_stb <= '0;
        end else begin
            if (wr_en) begin
                reg_mem[ptr_q] <= i2c_data_rx;
            end
            reg_wr_stb <= wr_stb_nxt;
        end
    end

    // Refreshed every cycle so the byte always tracks the settled pointer
    // and the live fabric value of read-only registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i2c_data_tx <= 8'h00;
        end else begin
            i2c_data_tx <= RO_MASK[ptr_q] ? hw_arr[ptr_q] : reg_mem[ptr_q];
        end
    end

endmodule

// File: tb/tb_i2c_reg_bank_ctrl.sv
module tb_i2c_reg_bank_ctrl;

    localparam int         PTR_W    = 3;
    localparam int         NUM_REGS = 8;
    localparam logic [7:0] RO_MASK  = 8'h80;
    localparam logic [7:0] RST_VAL  = 8'h3C;
`ifdef I2C_REG_AUTOINC_EN
    localparam bit         AUTOINC  = 1'b1;
`else
    localparam bit         AUTOINC  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  i2c_addr_rw;
    logic        i2c_addr_rw_valid_stb;
    logic [7:0]  i2c_data_rx;
    logic        i2c_data_rx_valid_stb;
    logic [7:0]  i2c_data_tx;
    logic        i2c_data_tx_loaded_stb;
    logic        i2c_data_tx_done_stb;
    logic        i2c_error_stb;
    logic        stall;
    logic [63:0] reg_q;
    logic [7:0]  reg_wr_stb;
    logic [63:0] reg_hw_in;
    logic [2:0]  ptr;

    always #5 clk = ~clk;

    i2c_reg_bank_ctrl #(
        .PTR_W   (PTR_W),
        .RO_MASK (RO_MASK),
        .RST_VAL (RST_VAL)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .i2c_addr_rw            (i2c_addr_rw),
        .i2c_addr_rw_valid_stb  (i2c_addr_rw_valid_stb),
        .i2c_data_rx            (i2c_data_rx),
        .i2c_data_rx_valid_stb  (i2c_data_rx_valid_stb),
        .i2c_data_tx            (i2c_data_tx),
        .i2c_data_tx_loaded_stb (i2c_data_tx_loaded_stb),
        .i2c_data_tx_done_stb   (i2c_data_tx_done_stb),
        .i2c_error_stb          (i2c_error_stb),
        .stall                  (stall),
        .reg_q                  (reg_q),
        .reg_wr_stb             (reg_wr_stb),
        .reg_hw_in              (reg_hw_in),
        .ptr                    (ptr)
    );

    // Transaction-level reference: register array, fabric inputs, pointer.
    logic [7:0] m_reg [NUM_REGS];
    logic [7:0] m_hw  [NUM_REGS];
    int         m_ptr;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_q();
        logic [63:0] v;
        for (int i = 0; i < NUM_REGS; i++) v[8*i +: 8] = m_reg[i];
        return v;
    endfunction

    function automatic logic [7:0] model_rd();
        return RO_MASK[m_ptr] ? m_hw[m_ptr] : m_reg[m_ptr];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) m_reg[i] = RST_VAL;
        m_ptr = 0;
    endtask

    task automatic set_hw();
        for (int i = 0; i < NUM_REGS; i++) reg_hw_in[8*i +: 8] = m_hw[i];
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_addr(input bit rw);
        i2c_addr_rw = {7'h42, rw};
        i2c_addr_rw_valid_stb = 1'b1;
        @(negedge clk);
        i2c_addr_rw_valid_stb = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input bit err);
        i2c_data_rx = b;
        i2c_data_rx_valid_stb = 1'b1;
        i2c_error_stb = err;
        @(negedge clk);
        i2c_data_rx_valid_stb = 1'b0;
        i2c_error_stb = 1'b0;
    endtask

    // Counts consecutive sampled cycles of stall, bounded.
    task automatic measure_stall(output int n);
        n = 0;
        while (stall === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic write_txn(input int n, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] b;
        logic [7:0] e;
        send_addr(1'b0);
        idle($urandom_range(0, 2));
        for (int i = 0; i < n; i++) begin
            b = (i == 0) ? b0 : (i == 1) ? b1 : (i == 2) ? b2 : b3;
            send_rx(b, 1'b0);
            e = '0;
            if (i == 0) begin
                m_ptr = int'(b) % NUM_REGS;
            end else begin
                if (!RO_MASK[m_ptr]) begin
                    m_reg[m_ptr] = b;
                    e[m_ptr] = 1'b1;
                end
                if (AUTOINC) m_ptr = (m_ptr + 1) % NUM_REGS;
            end
            chk("wr_stb", 64'(reg_wr_stb), 64'(e));
            chk("reg_q", reg_q, model_q());
            @(negedge clk);
            chk("wr_stb_pulse", 64'(reg_wr_stb), 64'd0);
            idle($urandom_range(0, 2));
        end
        chk("ptr_after_wr", 64'(ptr), 64'(m_ptr));
    endtask

    task automatic read_txn(input int n);
        int k;
        send_addr(1'b1);
        measure_stall(k);
        chk("stall_entry", 64'(k), 64'd2);
        for (int i = 0; i < n; i++) begin
            chk("rd_dat", 64'(i2c_data_tx), 64'(model_rd()));
            i2c_data_tx_loaded_stb = 1'b1;
            @(negedge clk);
            i2c_data_tx_loaded_stb = 1'b0;
            if (AUTOINC) m_ptr = (m_ptr + 1) % NUM_REGS;
            measure_stall(k);
            chk("stall_adv", 64'(k), AUTOINC ? 64'd2 : 64'd0);
            idle($urandom_range(0, 2));
            i2c_data_tx_done_stb = 1'b1;
            @(negedge clk);
            i2c_data_tx_done_stb = 1'b0;
        end
        chk("ptr_after_rd", 64'(ptr), 64'(m_ptr));
    endtask

    initial begin
        int n;
        rst = 1'b1;
        i2c_addr_rw = 8'h00;
        i2c_addr_rw_valid_stb = 1'b0;
        i2c_data_rx = 8'h00;
        i2c_data_rx_valid_stb = 1'b0;
        i2c_data_tx_loaded_stb = 1'b0;
        i2c_data_tx_done_stb = 1'b0;
        i2c_error_stb = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) m_hw[i] = 8'($urandom);
        set_hw();
        model_reset();
        idle(2);

        chk("rst_reg_q", reg_q, model_q());
        chk("rst_wr_stb", 64'(reg_wr_stb), 64'd0);
        chk("rst_tx", 64'(i2c_data_tx), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_ptr", 64'(ptr), 64'd0);
        rst = 1'b0;
        idle(2);

        // Single write, then burst write wrapping over the read-only register 7.
        write_txn(2, 8'h01, 8'hA5, 8'h00, 8'h00);
        write_txn(4, 8'h06, 8'h11, 8'h22, 8'h33);

        // Read-only register: write dropped, read returns fabric value.
        m_hw[7] = 8'hFF;
        set_hw();
        write_txn(2, 8'h07, 8'h55, 8'h00, 8'h00);
        read_txn(1);

        // Pointer-only write followed by a repeated-START read of three bytes.
        write_txn(1, 8'h02, 8'h00, 8'h00, 8'h00);
        read_txn(3);

        // Data byte arriving while reading is ignored.
        send_rx(8'hEE, 1'b0);
        chk("rx_in_rd_stb", 64'(reg_wr_stb), 64'd0);
        chk("rx_in_rd_q", reg_q, model_q());

        // Error in the same cycle as a data byte: no write, back to IDLE.
        write_txn(1, 8'h04, 8'h00, 8'h00, 8'h00);
        send_rx(8'h99, 1'b1);
        chk("err_stb", 64'(reg_wr_stb), 64'd0);
        chk("err_q", reg_q, model_q());
        chk("err_ptr", 64'(ptr), 64'(m_ptr));
        chk("err_stall", 64'(stall), 64'd0);
        send_rx(8'h77, 1'b0);
        chk("idle_rx_stb", 64'(reg_wr_stb), 64'd0);
        chk("idle_rx_q", reg_q, model_q());
        read_txn(1);

        // Repeated writes to one register.
        write_txn(3, 8'h03, 8'h10, 8'h20, 8'h00);

        // Randomised transactions, including pointer bytes with upper bits set.
        for (int t = 0; t < 16; t++) begin
            n = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 1) begin
                write_txn(n, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            end else begin
                for (int i = 0; i < NUM_REGS; i++) m_hw[i] = 8'($urandom);
                set_hw();
                read_txn(n);
            end
        end

        // Asynchronous reset in the middle of a read stall.
        send_addr(1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_stall", 64'(stall), 64'd0);
        chk("arst_ptr", 64'(ptr), 64'd0);
        model_reset();
        chk("arst_q", reg_q, model_q());
        chk("arst_tx", 64'(i2c_data_tx), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        read_txn(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
